// File: rtl/regfile_write_demux.sv
// Write side of the 32 x 64-bit register file: one-entry pending write stage,
// next-cycle commit into the array, and bypass of pending data to both read ports.
module regfile_write_demux #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             wr_valid_i,
  input  logic [4:0]       wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [4:0]       rd_addr1_i,
  input  logic [4:0]       rd_addr2_i,
  output logic [WIDTH-1:0] rd_data1_o,
  output logic [WIDTH-1:0] rd_data2_o,
  output logic [NREGS-1:0] wr_en_onehot_o,
  output logic             pend_valid_o
);

  localparam logic [4:0] ZeroAddr = 5'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             pendValid_q;
  logic [4:0]       pendAddr_q;
  logic [WIDTH-1:0] pendData_q;
  logic [NREGS-1:0] wrEnOnehot_q;

  logic             pendValid_d;
  logic [NREGS-1:0] wrEnOnehot_d;

  always_comb begin
    pendValid_d  = wr_valid_i && (wr_addr_i != ZeroAddr);
    wrEnOnehot_d = '0;
    if (pendValid_d) begin
      wrEnOnehot_d = {{(NREGS-1){1'b0}}, 1'b1} << wr_addr_i;
    end
  end

  // Commit uses the pre-edge pending entry while the new request is captured.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pendValid_q  <= 1'b0;
      pendAddr_q   <= '0;
      pendData_q   <= '0;
      wrEnOnehot_q <= '0;
    end else begin
      if (pendValid_q) begin
        regs_q[pendAddr_q] <= pendData_q;
      end
      pendValid_q  <= pendValid_d;
      wrEnOnehot_q <= wrEnOnehot_d;
      if (pendValid_d) begin
        pendAddr_q <= wr_addr_i;
        pendData_q <= wr_data_i;
      end
    end
  end

  function automatic logic [WIDTH-1:0] readPort(input logic [4:0] addr);
    logic [WIDTH-1:0] data;
    if (addr == ZeroAddr) begin
      data = '0;
    end else if (pendValid_q && (pendAddr_q == addr)) begin
      data = pendData_q;
    end else begin
      data = regs_q[addr];
    end
    return data;
  endfunction

  always_comb begin
    rd_data1_o = readPort(rd_addr1_i);
    rd_data2_o = readPort(rd_addr2_i);
  end

  assign wr_en_onehot_o = wrEnOnehot_q;
  assign pend_valid_o   = pendValid_q;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed bench for regfile_write_demux: reset, bypass latency, XZR, back-to-back,
// reset discard, and a long stream checked against a simple visibility model.
module tb_regfile_write_demux;

  logic        clk;
  logic        resetN;
  logic        wrValid;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [4:0]  rdAddr1;
  logic [4:0]  rdAddr2;
  logic [63:0] rdData1;
  logic [63:0] rdData2;
  logic [31:0] wrEnOnehot;
  logic        pendValid;

  int compared;
  int mismatched;

  regfile_write_demux dut (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .wr_valid_i     (wrValid),
    .wr_addr_i      (wrAddr),
    .wr_data_i      (wrData),
    .rd_addr1_i     (rdAddr1),
    .rd_addr2_i     (rdAddr2),
    .rd_data1_o     (rdData1),
    .rd_data2_o     (rdData2),
    .wr_en_onehot_o (wrEnOnehot),
    .pend_valid_o   (pendValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN  = 1'b0;
    wrValid = 1'b1;
    wrAddr  = 5'd9;
    wrData  = 64'h1234;
    step();
    step();
    resetN  = 1'b1;
    wrValid = 1'b0;
    #1;
    compared++;
    if (pendValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_pend_valid got %b want 0", pendValid);
    end
    compared++;
    if (wrEnOnehot !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_onehot got %h want 0", wrEnOnehot);
    end
    for (int i = 0; i < 32; i++) begin
      rdAddr1 = 5'(i);
      rdAddr2 = 5'(31 - i);
      #1;
      compared++;
      if (rdData1 !== 64'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_rd1[%0d] got %h want 0", i, rdData1);
      end
      compared++;
      if (rdData2 !== 64'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_rd2[%0d] got %h want 0", 31 - i, rdData2);
      end
    end
  endtask

  task automatic test_write_bypass();
    wrValid = 1'b1;
    wrAddr  = 5'd5;
    wrData  = 64'hDEADBEEF_01234567;
    rdAddr1 = 5'd5;
    rdAddr2 = 5'd4;
    #1;
    compared++;
    if (rdData1 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL x5_same_cycle got %h want 0", rdData1);
    end
    step();
    wrValid = 1'b0;
    #1;
    compared++;
    if (rdData1 !== 64'hDEADBEEF_01234567) begin
      mismatched++;
      $display("[TB] FAIL x5_bypass got %h want deadbeef01234567", rdData1);
    end
    compared++;
    if (pendValid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL x5_pend_valid got %b want 1", pendValid);
    end
    compared++;
    if (wrEnOnehot !== 32'h0000_0020) begin
      mismatched++;
      $display("[TB] FAIL x5_onehot got %h want 00000020", wrEnOnehot);
    end
    compared++;
    if (rdData2 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL x4_untouched got %h want 0", rdData2);
    end
    step();
    compared++;
    if (rdData1 !== 64'hDEADBEEF_01234567) begin
      mismatched++;
      $display("[TB] FAIL x5_array got %h want deadbeef01234567", rdData1);
    end
    compared++;
    if (pendValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL x5_pend_clear got %b want 0", pendValid);
    end
    compared++;
    if (wrEnOnehot !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL x5_onehot_clear got %h want 0", wrEnOnehot);
    end
  endtask

  task automatic test_zero_reg();
    wrValid = 1'b1;
    wrAddr  = 5'd31;
    wrData  = 64'hFFFF_FFFF_FFFF_FFFF;
    rdAddr1 = 5'd31;
    rdAddr2 = 5'd31;
    step();
    wrValid = 1'b0;
    #1;
    compared++;
    if (pendValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL xzr_pend_valid got %b want 0", pendValid);
    end
    compared++;
    if (wrEnOnehot !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL xzr_onehot got %h want 0", wrEnOnehot);
    end
    step();
    compared++;
    if (rdData1 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL xzr_rd1 got %h want 0", rdData1);
    end
    compared++;
    if (rdData2 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL xzr_rd2 got %h want 0", rdData2);
    end
  endtask

  task automatic test_back_to_back();
    rdAddr1 = 5'd7;
    wrValid = 1'b1;
    wrAddr  = 5'd7;
    wrData  = 64'h1;
    step();
    wrData  = 64'h2;
    #1;
    compared++;
    if (rdData1 !== 64'h1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first got %h want 1", rdData1);
    end
    step();
    wrValid = 1'b0;
    #1;
    compared++;
    if (rdData1 !== 64'h2) begin
      mismatched++;
      $display("[TB] FAIL b2b_second got %h want 2", rdData1);
    end
    step();
    step();
    compared++;
    if (rdData1 !== 64'h2) begin
      mismatched++;
      $display("[TB] FAIL b2b_settled got %h want 2", rdData1);
    end
    rdAddr1 = 5'd6;
    rdAddr2 = 5'd8;
    #1;
    compared++;
    if (rdData1 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL b2b_x6 got %h want 0", rdData1);
    end
    compared++;
    if (rdData2 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL b2b_x8 got %h want 0", rdData2);
    end
  endtask

  task automatic test_reset_discard();
    wrValid = 1'b1;
    wrAddr  = 5'd3;
    wrData  = 64'hAAAA;
    rdAddr1 = 5'd3;
    rdAddr2 = 5'd5;
    step();
    resetN  = 1'b0;
    wrAddr  = 5'd4;
    wrData  = 64'hBBBB;
    step();
    resetN  = 1'b1;
    wrValid = 1'b0;
    #1;
    compared++;
    if (pendValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL discard_pend_valid got %b want 0", pendValid);
    end
    compared++;
    if (rdData1 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL discard_x3 got %h want 0", rdData1);
    end
    compared++;
    if (rdData2 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL discard_x5 got %h want 0", rdData2);
    end
    step();
    rdAddr2 = 5'd4;
    #1;
    compared++;
    if (rdData1 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL discard_x3_later got %h want 0", rdData1);
    end
    compared++;
    if (rdData2 !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL discard_x4 got %h want 0", rdData2);
    end
  endtask

  // Model holds the value visible to readers, i.e. every accepted write from prior edges.
  task automatic test_stream();
    logic [63:0] model [32];
    logic        v;
    logic [4:0]  a;
    logic [63:0] d;
    logic [31:0] expOnehot;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    for (int n = 0; n < 1000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      a = 5'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      wrValid = v;
      wrAddr  = a;
      wrData  = d;
      rdAddr1 = 5'($urandom_range(0, 31));
      rdAddr2 = ($urandom_range(0, 1) != 0) ? a : 5'($urandom_range(0, 31));
      #1;
      compared++;
      if (rdData1 !== model[rdAddr1]) begin
        mismatched++;
        $display("[TB] FAIL stream_rd1 cyc %0d addr %0d got %h want %h", n, rdAddr1, rdData1, model[rdAddr1]);
      end
      compared++;
      if (rdData2 !== model[rdAddr2]) begin
        mismatched++;
        $display("[TB] FAIL stream_rd2 cyc %0d addr %0d got %h want %h", n, rdAddr2, rdData2, model[rdAddr2]);
      end
      step();
      expOnehot = 32'h0;
      if (v && a != 5'd31) begin
        model[a]  = d;
        expOnehot = 32'h1 << a;
      end
      compared++;
      if (pendValid !== (v && a != 5'd31)) begin
        mismatched++;
        $display("[TB] FAIL stream_pend cyc %0d got %b want %b", n, pendValid, (v && a != 5'd31));
      end
      compared++;
      if (wrEnOnehot !== expOnehot || !$onehot0(wrEnOnehot)) begin
        mismatched++;
        $display("[TB] FAIL stream_onehot cyc %0d got %h want %h", n, wrEnOnehot, expOnehot);
      end
    end
    wrValid = 1'b0;
    step();
    step();
    for (int i = 0; i < 32; i++) begin
      rdAddr1 = 5'(i);
      #1;
      compared++;
      if (rdData1 !== model[i]) begin
        mismatched++;
        $display("[TB] FAIL stream_final x%0d got %h want %h", i, rdData1, model[i]);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetN     = 1'b0;
    wrValid    = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    rdAddr1    = '0;
    rdAddr2    = '0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_back_to_back();
    test_reset_discard();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_demux.md
Name: regfile_write_demux

Overview:
- Write side of the 32 x 64-bit ARM register file, the counterpart of the read-select muxes.
- Decodes a 5-bit write address into a one-hot register enable and holds the write in a one-entry pending stage.
- Commits the pending write to the register array one cycle later.
- Bypasses pending data to the two combinational read ports so write-back is visible to decode on the next cycle.
- Register 31 (XZR) is hardwired to zero.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of registers. Address width is fixed at 5.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- wr_valid  input  1  write request this cycle
- wr_addr  input  5  destination register
- wr_data  input  WIDTH  write data
- rd_addr1  input  5  read port 1 address
- rd_addr2  input  5  read port 2 address
- rd_data1  output  WIDTH  read port 1 data, combinational
- rd_data2  output  WIDTH  read port 2 data, combinational
- wr_en_onehot  output  NREGS  registered decoded enable of the pending write
- pend_valid  output  1  a write is pending commit

Behaviour:
- Clock/reset: single clock domain, clk. Reset is synchronous, active-low, on reset_n.
- Reset, on an edge with reset_n = 0:
  - all registers go to 0;
  - pend_valid = 0, pend_addr = 0, pend_data = 0;
  - wr_en_onehot = 0.
  - A pending write is discarded, not committed.
  - wr_valid in the same cycle is ignored.
- Capture stage, on each edge with reset_n = 1:
  - If wr_valid = 1 and wr_addr != ZERO_REG: pend_valid <= 1, pend_addr <= wr_addr, pend_data <= wr_data, wr_en_onehot <= 1 << wr_addr.
  - Otherwise: pend_valid <= 0 and wr_en_onehot <= 0. pend_addr and pend_data hold.
- Commit stage, on the same edge, using the pre-edge pending values:
  - If pend_valid = 1: regs[pend_addr] <= pend_data.
  - Commit and capture happen in the same cycle with no stall. Throughput is one write per cycle.
- Read ports (each port independent, purely combinational):
  - rd_addr == ZERO_REG -> 0;
  - else pend_valid && pend_addr == rd_addr -> pend_data (bypass);
  - else regs[rd_addr].
- Latency: a write presented in cycle N is readable from cycle N+1 via bypass, and from the array from cycle N+2.
- Back-to-back writes to the same address:
  - the older write commits while the newer one captures;
  - reads see the newer value from the next cycle;
  - the array ends holding the newer value.
- Same-cycle read of an address being presented on wr_*: returns the old value. There is no input-to-output combinational bypass.
- The write to ZERO_REG is dropped with no side effects. wr_en_onehot[31] is never set.
- No X propagation: rd_data must be defined for every address after reset.

Test Plan:
- Reset then read all 32 addresses on both ports -> every read is 0; pend_valid = 0; wr_en_onehot = 0.
- Write X5 = 64'hDEADBEEF_01234567 in cycle N:
  - cycle N+1: rd_data1 = that value (bypass), pend_valid = 1, wr_en_onehot = 32'h0000_0020;
  - cycle N+2: the same value is read from the array with pend_valid = 0.
- Write X31 = 64'hFFFF_FFFF_FFFF_FFFF -> pend_valid stays 0, wr_en_onehot = 0, rd(X31) = 0 on both ports.
- Back-to-back X7 = 64'h1 then X7 = 64'h2 -> reads give 1 in the first cycle after, 2 from the second cycle on, and X7 = 2 after settling; neighbour X6/X8 remain 0.
- Write X3 = 64'hAAAA, then assert reset_n = 0 on the next edge while it is pending -> X3 reads 0 after reset; the write was discarded.
- Random 1000-cycle stream of valid/addr/data with random reads on both ports vs. a reference model -> zero mismatches; wr_en_onehot is one-hot or zero every cycle.
